// File: rtl/d_latch_pkg.sv
// Shared definitions for the gated D latch: default width and the gate function.
package d_latch_pkg;

    localparam int unsigned D_LATCH_DEF_WIDTH = 1;

    // Transparency gate: open only while both the clock and the enable are high.
    function automatic logic gate_open(input logic clk, input logic en);
        return clk & en;
    endfunction

endpackage

// File: rtl/d_latch_bit.sv
// One-bit level-sensitive storage cell with asynchronous active-low reset.
//   g      : gate, transparent while high
//   rst_n  : asynchronous reset, loads RST_VAL and dominates the gate
//   d      : data in
//   q      : stored / transparent data out
module d_latch_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic g,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic q_q;

    // Intentional latch: reset first, then transparency while the gate is open.
    always_latch begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else if (g) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/d_latch.sv
// Clock-gated, enabled D latch with complementary outputs.
//   clk    : gate clock, transparent while high (qualified by en)
//   rst_n  : asynchronous active-low reset, Q <= RST_VAL
//   en     : enable, transparent only while en=1 and clk=1
//   D      : data in  [WIDTH]
//   Q      : latched data [WIDTH]
//   Qn     : bitwise complement of Q [WIDTH]
module d_latch
    import d_latch_pkg::*;
#(
    parameter int unsigned          WIDTH   = D_LATCH_DEF_WIDTH,
    parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic g;

    // Single shared gate so every bit opens and closes together.
    assign g = gate_open(clk, en);

    // Independent per-bit cells; each carries its own reset value.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        d_latch_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .g     (g),
            .rst_n (rst_n),
            .d     (D[i]),
            .q     (Q[i])
        );
    end

    // Complement is derived from the stored value, so it tracks Q through reset too.
    assign Qn = ~Q;

endmodule

// File: tb/tb_d_latch.sv
module tb_d_latch;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    d_latch #(
        .WIDTH   (W),
        .RST_VAL (4'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .D     (D),
        .Q     (Q),
        .Qn    (Qn)
    );

    // clk=0 at t=0, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic at(input time t);
        #(t - $time);
    endtask

    task automatic push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag);
        logic [W-1:0] e;
        logic [W-1:0] en_exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, Q=%h", tag, Q);
            return;
        end
        e = exp_q.pop_front();
        en_exp = ~e;
        assert (Q === e) else begin
            bad++;
            $error("FAIL %s: Q=%h expected %h", tag, Q, e);
        end
        total++;
        assert (Qn === en_exp) else begin
            bad++;
            $error("FAIL %s_n: Qn=%h expected %h", tag, Qn, en_exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        D     = 4'hF;
        en    = 1'b1;

        at(1);   push(4'h0); chk("reset_hold");
        at(2);   rst_n = 1'b1;
        at(3);   push(4'h0); chk("release_gate_closed");
        en = 1'b0; D = 4'h0;
        at(7);   push(4'h0); chk("clk_high_en_low");

        at(11);  D = 4'hF; en = 1'b1; push(4'h0);
        at(12);  chk("wait_for_clk");
        at(16);  push(4'hF); chk("open_on_clk_rise");
        at(17);  D = 4'h3; push(4'h3);
        at(18);  chk("follow_d");
        D = 4'hA; push(4'hA);
        at(19);  chk("follow_d2");

        at(21);  D = 4'h0; en = 1'b0; push(4'hA);
        at(26);  chk("hold_en_low");
        at(31);  D = 4'hF; push(4'hA);
        at(36);  chk("hold_en_low2");

        at(41);  D = 4'h6; en = 1'b1; push(4'hA);
        at(43);  chk("hold_clk_low");
        at(46);  push(4'h6); chk("open_on_clk_rise2");

        at(51);  D = 4'h9; en = 1'b0;
        at(56);  push(4'h6); chk("closed_a");
        at(66);  push(4'h6); chk("closed_b");
        at(74);  push(4'h6); chk("closed_c");

        at(81);  en = 1'b1; D = 4'hC;
        at(86);  push(4'hC); chk("reopen");
        @(negedge clk);
        D = 4'h3; push(4'hC);
        at(91);  chk("clk_fall_capture");
        at(96);  push(4'h3); chk("reopen2");
        at(97);  en = 1'b0; D = 4'hE; push(4'h3);
        at(98);  chk("en_fall_capture");

        at(101); en = 1'b1; D = 4'hF;
        at(106); push(4'hF); chk("open_pre_reset");
        rst_n = 1'b0; push(4'h0);
        at(107); chk("async_reset_open");
        at(108); rst_n = 1'b1; push(4'hF);
        at(109); chk("release_gate_open");

        at(111); en = 1'b0; D = 4'h5;
        at(116); push(4'hF); chk("clk_high_en_low2");
        en = 1'b1; push(4'h5);
        at(117); chk("open_on_en_rise");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain: left=%0d expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
